rotary_encoder_decoder: RTL and testbench

//  Front-panel rotary encoder front end. Takes raw encoder_A/B/sw pins (aux[6], aux[2], aux[1]), synchronises and

---
 rtl/rotary_encoder_decoder.sv | 116 +++++++++++
 tb/tb_rotary_encoder_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rotary_encoder_decoder.sv
// rotary_encoder_decoder: synchronises and debounces encoder A/B/sw, decodes quadrature into a
// saturating signed detent count with a sticky press flag; an SPI read strobe clears the register.
module rotary_encoder_decoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DETENT_STEPS    = 4,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        encoder_A,
    input  logic        encoder_B,
    input  logic        encoder_sw,
    input  logic        rotary_encoder_rd_stb,
    output logic [7:0]  rotary_encoder_reg,
    output logic [15:0] test
);
    typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10} quad_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [2:0] ACC_TOP  = 3'(DETENT_STEPS - 1);
    localparam logic signed [2:0] ACC_BOT  = 3'(1 - DETENT_STEPS);
    localparam logic signed [5:0] CNT_MAX  = 6'sd31;
    localparam logic signed [5:0] CNT_MIN  = 6'sb100000;

    logic [2:0] raw, sync1, sync2, filt;
    quad_t q_state, q_next, cw_tgt, ccw_tgt;
    logic signed [2:0] acc, acc_next;
    logic step_cw, step_ccw, illegal, emit_up, emit_dn;
    logic signed [5:0] count, count_next;
    logic sat, sat_next, press, press_next, sw_d, press_edge, cnt_hi, cnt_lo;

    assign raw = {encoder_A, encoder_B, encoder_sw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Each filtered bit only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic f;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                f   <= 1'b1;
            end else if (sync2[g] == f) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                f   <= sync2[g];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign filt[g] = f;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_state <= S11;
            acc     <= '0;
        end else begin
            q_state <= q_next;
            acc     <= acc_next;
        end
    end

    always_comb begin
        q_next   = quad_t'(filt[2:1]);
        cw_tgt   = (q_state == S00) ? S01 : (q_state == S01) ? S11 : (q_state == S11) ? S10 : S00;
        ccw_tgt  = (q_state == S00) ? S10 : (q_state == S10) ? S11 : (q_state == S11) ? S01 : S00;
        step_cw  = (q_next != q_state) && (q_next == cw_tgt);
        step_ccw = (q_next != q_state) && (q_next == ccw_tgt);
        illegal  = (q_next ^ q_state) == 2'b11;
        emit_up  = step_cw && (acc == ACC_TOP);
        emit_dn  = step_ccw && (acc == ACC_BOT);
        acc_next = (illegal || emit_up || emit_dn) ? 3'sd0 :
                   step_cw  ? acc + 3'sd1 :
                   step_ccw ? acc - 3'sd1 : acc;
    end

    // A detent landing in the read cycle survives the clear as +/-1.
    always_comb begin
        press_edge = sw_d & ~filt[0];
        cnt_hi     = emit_up && (count == CNT_MAX);
        cnt_lo     = emit_dn && (count == CNT_MIN);
        count_next = rotary_encoder_rd_stb ? (emit_up ? 6'sd1 : emit_dn ? -6'sd1 : 6'sd0) :
                     (emit_up && !cnt_hi) ? count + 6'sd1 :
                     (emit_dn && !cnt_lo) ? count - 6'sd1 : count;
        sat_next   = rotary_encoder_rd_stb ? 1'b0 : (sat | cnt_hi | cnt_lo);
        press_next = rotary_encoder_rd_stb ? press_edge : (press | press_edge);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            sat   <= 1'b0;
            press <= 1'b0;
            sw_d  <= 1'b1;
        end else begin
            count <= count_next;
            sat   <= sat_next;
            press <= press_next;
            sw_d  <= filt[0];
        end
    end

    assign rotary_encoder_reg = {press, sat, count};
    assign test = {rotary_encoder_reg, acc, q_state, filt[0], filt[2], filt[1]};
endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// tb_rotary_encoder_decoder: directed vector table plus hand sequences for debounce,
// read-strobe collisions, illegal transitions and async reset.
module tb_rotary_encoder_decoder;
    logic clk = 1'b0, rst_n = 1'b0, a = 1'b1, b = 1'b1, sw = 1'b1, rd = 1'b0;
    logic [7:0] rreg;
    logic [15:0] test;
    int checks = 0, errors = 0;

    typedef struct {
        int         steps;
        bit         rd;
        logic [7:0] exp_reg;
        logic [2:0] exp_sub;
    } vec_t;
    vec_t tbl[10];

    rotary_encoder_decoder #(.DEBOUNCE_CYCLES(4), .DETENT_STEPS(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(rst_n), .encoder_A(a), .encoder_B(b), .encoder_sw(sw),
        .rotary_encoder_rd_stb(rd), .rotary_encoder_reg(rreg), .test(test)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] cw_f(input logic [1:0] s);
        return (s == 2'b00) ? 2'b01 : (s == 2'b01) ? 2'b11 : (s == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] ccw_f(input logic [1:0] s);
        return (s == 2'b00) ? 2'b10 : (s == 2'b10) ? 2'b11 : (s == 2'b11) ? 2'b01 : 2'b00;
    endfunction

    task automatic set_ab(input logic [1:0] v);
        @(negedge clk);
        {a, b} = v;
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input int dir);
        set_ab(dir > 0 ? cw_f({a, b}) : ccw_f({a, b}));
    endtask

    task automatic strobe();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {a, b, sw, rd} = 4'b1110;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int bad, n;
        tbl[0] = '{12,   1'b0, 8'h03, 3'd0};
        tbl[1] = '{0,    1'b1, 8'h00, 3'd0};
        tbl[2] = '{-4,   1'b0, 8'h3F, 3'd0};
        tbl[3] = '{2,    1'b0, 8'h3F, 3'd2};
        tbl[4] = '{-2,   1'b0, 8'h3F, 3'd0};
        tbl[5] = '{4,    1'b0, 8'h00, 3'd0};
        tbl[6] = '{160,  1'b0, 8'h5F, 3'd0};
        tbl[7] = '{0,    1'b1, 8'h00, 3'd0};
        tbl[8] = '{-160, 1'b0, 8'h60, 3'd0};
        tbl[9] = '{0,    1'b1, 8'h00, 3'd0};

        do_reset();
        check("reset_reg", {8'h00, rreg}, 16'h0000);
        check("reset_test", test, 16'h001F);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rd) strobe();
            for (int s = 0; s < (tbl[i].steps < 0 ? -tbl[i].steps : tbl[i].steps); s++)
                step(tbl[i].steps);
            check($sformatf("vec%0d_reg", i), {8'h00, rreg}, {8'h00, tbl[i].exp_reg});
            check($sformatf("vec%0d_sub", i), {13'h0, test[7:5]}, {13'h0, tbl[i].exp_sub});
        end

        // Short glitches on A must never reach the filtered value.
        do_reset();
        bad = 0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            a = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (!test[1]) bad++;
            end
            a = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (!test[1]) bad++;
            end
        end
        check("glitch_filt_changes", bad[15:0], 16'h0000);
        check("glitch_reg", {8'h00, rreg}, 16'h0000);
        @(negedge clk);
        a = 1'b0;
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(negedge clk);
            if (!test[1]) n = k;
        end
        check("a_fall_latency", n[15:0], 16'd6);
        repeat (10) @(negedge clk);
        check("a_low_sub", {13'h0, test[7:5]}, 16'h0007);
        set_ab(2'b11);
        check("a_back_sub", {13'h0, test[7:5]}, 16'h0000);

        // Press, then a read strobe that lands exactly on a detent emit.
        do_reset();
        @(negedge clk);
        sw = 1'b0;
        repeat (50) @(posedge clk);
        sw = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("press_reg", {8'h00, rreg}, 16'h0080);
        repeat (3) step(1);
        check("press_sub3", {13'h0, test[7:5]}, 16'h0003);
        {a, b} = cw_f({a, b});
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("emit_filt_ab", {14'h0, test[1:0]}, 16'h0003);
        check("pre_strobe_reg", {8'h00, rreg}, 16'h0080);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("post_strobe_reg", {8'h00, rreg}, 16'h0001);
        repeat (10) @(negedge clk);
        check("post_strobe_hold", {8'h00, rreg}, 16'h0001);

        // Illegal double-bit jumps clear the accumulator without counting.
        do_reset();
        step(1);
        check("ill_sub_a", {13'h0, test[7:5]}, 16'h0001);
        set_ab(2'b01);
        check("ill_sub_b", {13'h0, test[7:5]}, 16'h0000);
        check("ill_state_b", {14'h0, test[4:3]}, 16'h0001);
        step(1);
        check("ill_sub_c", {13'h0, test[7:5]}, 16'h0001);
        set_ab(2'b00);
        check("ill_sub_d", {13'h0, test[7:5]}, 16'h0000);
        check("ill_reg_d", {8'h00, rreg}, 16'h0000);
        repeat (3) step(1);
        check("ill_reg_3", {8'h00, rreg}, 16'h0000);
        step(1);
        check("ill_reg_4", {8'h00, rreg}, 16'h0001);
        repeat (2) step(1);
        check("mid_sub", {13'h0, test[7:5]}, 16'h0002);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_test", test, 16'h001F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1);
        check("after_rst_3", {8'h00, rreg}, 16'h0000);
        step(1);
        check("after_rst_4", {8'h00, rreg}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
